writeback_stage_mp: RTL and testbench

//  Parametrised multi-lane writeback stage: final pipeline segment register between MEM and the register file.

---
 rtl/writeback_stage_mp_if.sv | 26 ++
 rtl/writeback_stage_mp.sv | 117 +++++++++++
 tb/tb_writeback_stage_mp.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_mp_if.sv
// MEM-to-writeback lane bus for writeback_stage_mp: per-lane results, load
// attributes and destination indices, plus the in_ready backpressure return.
interface writeback_stage_mp_if #(
   parameter int unsigned LANES  = 2,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RIDX_W = 5
);
   logic [LANES-1:0]        in_valid;
   logic                    in_ready;
   logic [LANES*DATA_W-1:0] ex_result;
   logic [LANES*DATA_W-1:0] mem_result;
   logic [LANES*2-1:0]      mem_offset;
   logic [LANES*3-1:0]      number_len;
   logic [LANES-1:0]        wb_src;
   logic [LANES*RIDX_W-1:0] rd_index_in;

   modport master (
      output in_valid, ex_result, mem_result, mem_offset, number_len, wb_src, rd_index_in,
      input  in_ready
   );

   modport slave (
      input  in_valid, ex_result, mem_result, mem_offset, number_len, wb_src, rd_index_in,
      output in_ready
   );
endinterface

// File: rtl/writeback_stage_mp.sv
// Multi-lane writeback segment register: sub-word load extension, youngest-lane-wins
// regfile write qualification. Optional retire counter under macro WB_RETIRE_CNT_EN.
module writeback_stage_mp #(
   parameter int unsigned LANES  = 2,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RIDX_W = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   writeback_stage_mp_if.slave     bus,
   input  logic                    wb_stall,
   input  logic                    wb_flush,
   output logic [LANES-1:0]        rf_we,
   output logic [LANES*RIDX_W-1:0] rf_waddr,
   output logic [LANES*DATA_W-1:0] rf_wdata
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0]             retire_cnt,
   input  logic                    retire_cnt_clr
`endif
);
   localparam int unsigned CNT_W = 32;

   logic [LANES-1:0]        seg_valid;
   logic [LANES*DATA_W-1:0] seg_ex;
   logic [LANES*DATA_W-1:0] seg_mem;
   logic [LANES*2-1:0]      seg_off;
   logic [LANES*3-1:0]      seg_len;
   logic [LANES-1:0]        seg_src;
   logic [LANES*RIDX_W-1:0] seg_rd;

   logic [RIDX_W-1:0]       lane_rd;
   logic                    waw_kill;

   assign bus.in_ready = !wb_stall;

   // Byte/half extraction by offset, then sign or zero fill by length code
   function automatic logic [DATA_W-1:0] ext_load(input logic [DATA_W-1:0] word,
                                                  input logic [1:0]        off,
                                                  input logic [2:0]        len);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (len)
         3'b000:  ext_load = {{(DATA_W-8){b[7]}}, b};
         3'b001:  ext_load = {{(DATA_W-16){h[15]}}, h};
         3'b100:  ext_load = {{(DATA_W-8){1'b0}}, b};
         3'b101:  ext_load = {{(DATA_W-16){1'b0}}, h};
         default: ext_load = word;
      endcase
   endfunction

   // Segment register: flush beats stall, data held on flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_valid <= '0;
         seg_ex    <= '0;
         seg_mem   <= '0;
         seg_off   <= '0;
         seg_len   <= '0;
         seg_src   <= '0;
         seg_rd    <= '0;
      end else if (wb_flush) begin
         seg_valid <= '0;
      end else if (!wb_stall) begin
         seg_valid <= bus.in_valid;
         seg_ex    <= bus.ex_result;
         seg_mem   <= bus.mem_result;
         seg_off   <= bus.mem_offset;
         seg_len   <= bus.number_len;
         seg_src   <= bus.wb_src;
         seg_rd    <= bus.rd_index_in;
      end
   end

   // Per-lane write qualification; a younger lane to the same rd suppresses older ones
   always_comb begin
      rf_we    = '0;
      rf_wdata = '0;
      rf_waddr = seg_rd;
      lane_rd  = '0;
      waw_kill = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         lane_rd  = seg_rd[l*RIDX_W +: RIDX_W];
         waw_kill = 1'b0;
         for (int k = l + 1; k < LANES; k++) begin
            if (seg_valid[k] && (seg_rd[k*RIDX_W +: RIDX_W] == lane_rd))
               waw_kill = 1'b1;
         end
         rf_we[l] = seg_valid[l] && (lane_rd != '0) && !waw_kill;
         rf_wdata[l*DATA_W +: DATA_W] = seg_src[l]
            ? ext_load(seg_mem[l*DATA_W +: DATA_W], seg_off[l*2 +: 2], seg_len[l*3 +: 3])
            : seg_ex[l*DATA_W +: DATA_W];
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] retire_add;

   always_comb begin
      retire_add = '0;
      for (int l = 0; l < LANES; l++)
         retire_add = retire_add + CNT_W'(seg_valid[l]);
   end

   // Stalled contents count only on their release edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         retire_cnt <= '0;
      else if (retire_cnt_clr)
         retire_cnt <= '0;
      else if (!wb_stall)
         retire_cnt <= retire_cnt + retire_add;
   end
`endif
endmodule

// File: tb/tb_writeback_stage_mp.sv
// Scoreboard bench for writeback_stage_mp (LANES=2): reference model pushes expected
// regfile outputs at drive time, compared one edge later.
module tb_writeback_stage_mp;
   logic        clk;
   logic        rst;
   logic        wb_stall;
   logic        wb_flush;
   logic [1:0]  rf_we;
   logic [9:0]  rf_waddr;
   logic [63:0] rf_wdata;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt;
   logic        retire_cnt_clr;
`endif

   writeback_stage_mp_if #(.LANES(2), .DATA_W(32), .RIDX_W(5)) bus ();

   writeback_stage_mp #(.LANES(2), .DATA_W(32), .RIDX_W(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .wb_stall (wb_stall),
      .wb_flush (wb_flush),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata)
`ifdef WB_RETIRE_CNT_EN
      ,
      .retire_cnt     (retire_cnt),
      .retire_cnt_clr (retire_cnt_clr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  we;
      logic [9:0]  waddr;
      logic [63:0] wdata;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Stimulus for the next cycle
   logic [1:0]  d_v;
   logic [31:0] d_ex  [2];
   logic [31:0] d_mem [2];
   logic [1:0]  d_off [2];
   logic [2:0]  d_len [2];
   logic        d_src [2];
   logic [4:0]  d_rd  [2];
   logic        d_stall, d_flush, d_clr;

   // Reference segment contents
   logic [1:0]  m_v;
   logic [31:0] m_ex  [2];
   logic [31:0] m_mem [2];
   logic [1:0]  m_off [2];
   logic [2:0]  m_len [2];
   logic        m_src [2];
   logic [4:0]  m_rd  [2];
   logic [31:0] m_cnt;

   logic [1:0]  save_we;
   logic [9:0]  save_waddr;
   logic [63:0] save_wdata;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_ext(input logic [31:0] mem, input logic [1:0] off,
                                           input logic [2:0] len);
      logic [31:0] b, h;
      int          sb_sh, sh_sh;
      sb_sh = 8 * int'(off);
      sh_sh = off[1] ? 16 : 0;
      b = (mem >> sb_sh) & 32'h0000_00FF;
      h = (mem >> sh_sh) & 32'h0000_FFFF;
      case (len)
         3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
         3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return mem;
      endcase
   endfunction

   task automatic model_reset();
      m_v   = 2'b00;
      m_cnt = 32'h0;
      for (int l = 0; l < 2; l++) begin
         m_ex[l] = '0; m_mem[l] = '0; m_off[l] = '0; m_len[l] = '0; m_src[l] = 1'b0; m_rd[l] = '0;
      end
   endtask

   task automatic set_lane(input int l, input logic [31:0] ex, input logic [31:0] mem,
                           input logic [1:0] off, input logic [2:0] len, input logic src,
                           input logic [4:0] rd);
      d_ex[l] = ex; d_mem[l] = mem; d_off[l] = off; d_len[l] = len; d_src[l] = src; d_rd[l] = rd;
   endtask

   // One cycle: drive at negedge, update model, push expectation, compare after posedge
   task automatic step();
      exp_t e;
      @(negedge clk);
      bus.in_valid    = d_v;
      bus.ex_result   = {d_ex[1], d_ex[0]};
      bus.mem_result  = {d_mem[1], d_mem[0]};
      bus.mem_offset  = {d_off[1], d_off[0]};
      bus.number_len  = {d_len[1], d_len[0]};
      bus.wb_src      = {d_src[1], d_src[0]};
      bus.rd_index_in = {d_rd[1], d_rd[0]};
      wb_stall        = d_stall;
      wb_flush        = d_flush;
`ifdef WB_RETIRE_CNT_EN
      retire_cnt_clr  = d_clr;
`endif
      #1;
      chk("in_ready", 64'(bus.in_ready), 64'(!d_stall));
      if (d_clr)
         m_cnt = 32'h0;
      else if (!d_stall)
         m_cnt = m_cnt + 32'(m_v[0]) + 32'(m_v[1]);
      if (d_flush) begin
         m_v = 2'b00;
      end else if (!d_stall) begin
         m_v = d_v;
         for (int l = 0; l < 2; l++) begin
            m_ex[l] = d_ex[l]; m_mem[l] = d_mem[l]; m_off[l] = d_off[l];
            m_len[l] = d_len[l]; m_src[l] = d_src[l]; m_rd[l] = d_rd[l];
         end
      end
      e.we[1]  = m_v[1] && (m_rd[1] != 5'd0);
      e.we[0]  = m_v[0] && (m_rd[0] != 5'd0) && !(m_v[1] && (m_rd[1] == m_rd[0]));
      e.waddr  = {m_rd[1], m_rd[0]};
      e.wdata  = {m_src[1] ? ref_ext(m_mem[1], m_off[1], m_len[1]) : m_ex[1],
                  m_src[0] ? ref_ext(m_mem[0], m_off[0], m_len[0]) : m_ex[0]};
      e.cnt    = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 64'(1), 64'(0));
      end else begin
         e = sb.pop_front();
         chk("rf_we", 64'(rf_we), 64'(e.we));
         chk("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
         chk("rf_wdata", rf_wdata, e.wdata);
`ifdef WB_RETIRE_CNT_EN
         chk("retire_cnt", 64'(retire_cnt), 64'(e.cnt));
`endif
      end
   endtask

   initial begin
      rst = 1'b1;
      d_v = 2'b00; d_stall = 1'b0; d_flush = 1'b0; d_clr = 1'b0;
      for (int l = 0; l < 2; l++) set_lane(l, 32'h0, 32'h0, 2'd0, 3'd0, 1'b0, 5'd0);
      bus.in_valid = '0; bus.ex_result = '0; bus.mem_result = '0; bus.mem_offset = '0;
      bus.number_len = '0; bus.wb_src = '0; bus.rd_index_in = '0;
      wb_stall = 1'b0; wb_flush = 1'b0;
`ifdef WB_RETIRE_CNT_EN
      retire_cnt_clr = 1'b0;
`endif
      model_reset();
      #12;
      chk("rst_we", 64'(rf_we), 64'(0));
      chk("rst_waddr", 64'(rf_waddr), 64'(0));
      chk("rst_wdata", rf_wdata, 64'(0));
      @(negedge clk);
      rst = 1'b0;

      // Signed / unsigned byte on lane 0
      d_v = 2'b11;
      set_lane(0, 32'h0, 32'h80FF_1234, 2'd3, 3'b000, 1'b1, 5'd3);
      set_lane(1, 32'h55, 32'h0, 2'd0, 3'b010, 1'b0, 5'd4);
      step();
      chk("byte_s", 64'(rf_wdata[31:0]), 64'(32'hFFFF_FF80));
      d_len[0] = 3'b100;
      step();
      chk("byte_u", 64'(rf_wdata[31:0]), 64'(32'h0000_0080));

      // Half and word on lane 1
      set_lane(1, 32'h0, 32'h8001_7FFF, 2'd2, 3'b001, 1'b1, 5'd4);
      step();
      chk("half_hi", 64'(rf_wdata[63:32]), 64'(32'hFFFF_8001));
      d_off[1] = 2'd0;
      step();
      chk("half_lo", 64'(rf_wdata[63:32]), 64'(32'h0000_7FFF));
      d_len[1] = 3'b010;
      step();
      chk("word", 64'(rf_wdata[63:32]), 64'(32'h8001_7FFF));

      // Same-cycle WAW and rd==0
      set_lane(0, 32'h11, 32'h0, 2'd0, 3'b010, 1'b0, 5'd7);
      set_lane(1, 32'h22, 32'h0, 2'd0, 3'b010, 1'b0, 5'd7);
      step();
      chk("waw_we", 64'(rf_we), 64'(2'b10));
      chk("waw_data1", 64'(rf_wdata[63:32]), 64'(32'h22));
      d_rd[0] = 5'd0; d_rd[1] = 5'd5;
      step();
      chk("rd0_we0", 64'(rf_we[0]), 64'(0));

      // Stall holds outputs, flush during stall kills
      set_lane(0, 32'hA5A5_0001, 32'h0, 2'd0, 3'b010, 1'b0, 5'd9);
      set_lane(1, 32'h5A5A_0002, 32'h0, 2'd0, 3'b010, 1'b0, 5'd10);
      step();
      save_we = rf_we; save_waddr = rf_waddr; save_wdata = rf_wdata;
      chk("pre_stall_we", 64'(save_we), 64'(2'b11));
      d_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_lane(0, $urandom, $urandom, 2'($urandom), 3'($urandom), 1'($urandom), 5'($urandom));
         set_lane(1, $urandom, $urandom, 2'($urandom), 3'($urandom), 1'($urandom), 5'($urandom));
         step();
         chk("stall_we", 64'(rf_we), 64'(save_we));
         chk("stall_waddr", 64'(rf_waddr), 64'(save_waddr));
         chk("stall_wdata", rf_wdata, save_wdata);
      end
      d_flush = 1'b1;
      step();
      chk("flush_we", 64'(rf_we), 64'(0));
      d_stall = 1'b0; d_flush = 1'b0;

      // Asynchronous reset mid-stream
      d_v = 2'b11;
      set_lane(0, 32'h1234_5678, 32'h0, 2'd0, 3'b010, 1'b0, 5'd1);
      set_lane(1, 32'h9ABC_DEF0, 32'h0, 2'd0, 3'b010, 1'b0, 5'd2);
      step();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("amid_rst_we", 64'(rf_we), 64'(0));
      chk("amid_rst_wdata", rf_wdata, 64'(0));
      chk("amid_rst_waddr", 64'(rf_waddr), 64'(0));
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Random traffic with small rd range to exercise WAW
      for (int i = 0; i < 80; i++) begin
         d_v = 2'($urandom);
         for (int l = 0; l < 2; l++)
            set_lane(l, $urandom, $urandom, 2'($urandom), 3'($urandom), 1'($urandom),
                     5'($urandom_range(0, 3)));
         d_stall = ($urandom_range(0, 3) == 0);
         d_flush = ($urandom_range(0, 7) == 0);
         d_clr   = ($urandom_range(0, 15) == 0);
         step();
      end
      d_stall = 1'b0; d_flush = 1'b0; d_clr = 1'b0;

`ifdef WB_RETIRE_CNT_EN
      // Clear, then count two per cycle; clear with valid contents wins
      d_clr = 1'b1; d_v = 2'b11;
      step();
      d_clr = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("cnt_5x2", 64'(retire_cnt), 64'(32'd10));
      d_clr = 1'b1;
      step();
      chk("cnt_clr", 64'(retire_cnt), 64'(0));
      d_clr = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
